ctrl_fsm: RTL

CTRL_FSM -- requirements
Module: ctrl_fsm

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/ctrl_fsm_if.sv | 30 +++
 rtl/ctrl_decode.sv | 60 ++++++
 rtl/ctrl_fsm.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ctrl_fsm instruction sequencer: state encoding,
// opcode class/sub-op constants and the EXEC-cycle decode bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam logic [1:0] CLS_ALU_REG = 2'b00;
    localparam logic [1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [1:0] CLS_BRANCH  = 2'b10;
    localparam logic [1:0] CLS_SYS     = 2'b11;

    localparam logic [1:0] SUB_JMP   = 2'b00;
    localparam logic [1:0] SUB_JZ    = 2'b01;
    localparam logic [1:0] SUB_JNZ   = 2'b10;
    localparam logic [1:0] SUB_JC    = 2'b11;

    localparam logic [1:0] SUB_LOAD  = 2'b00;
    localparam logic [1:0] SUB_STORE = 2'b01;
    localparam logic [1:0] SUB_NOP   = 2'b10;
    localparam logic [1:0] SUB_HALT  = 2'b11;

    typedef struct packed {
        logic reg_en;
        logic imm_sel;
        logic pc_inc;
        logic jmp_sel;
        logic to_mem;
        logic to_halt;
    } exec_dec_t;

    function automatic logic branch_taken(input logic [1:0] sub, input logic zf, input logic cf);
        logic taken;
        case (sub)
            SUB_JMP: taken = 1'b1;
            SUB_JZ:  taken = zf;
            SUB_JNZ: taken = ~zf;
            SUB_JC:  taken = cf;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// Control/handshake bundle between the sequencer (slave side) and the
// datapath/memory (master side).
interface ctrl_fsm_if #(
    parameter int OPW = 4
);
    logic [OPW-1:0] opcode;
    logic           zf;
    logic           cf;
    logic           mem_ack;
    logic           mem_req;
    logic           mem_we;
    logic           ir_load;
    logic           pc_inc;
    logic           jmp_sel;
    logic           imm_sel;
    logic           reg_en;
    logic [1:0]     alu_op;
    logic           halted;
    logic [2:0]     state;

    modport slave (
        input  opcode, zf, cf, mem_ack,
        output mem_req, mem_we, ir_load, pc_inc, jmp_sel, imm_sel, reg_en, alu_op, halted, state
    );

    modport master (
        output opcode, zf, cf, mem_ack,
        input  mem_req, mem_we, ir_load, pc_inc, jmp_sel, imm_sel, reg_en, alu_op, halted, state
    );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational map from a latched opcode plus ALU flags to the
// strobes and next-state hints used in the EXEC cycle.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opc,
    input  logic           zf,
    input  logic           cf,
    output exec_dec_t      dec
);
    logic [1:0] cls_s;
    logic [1:0] sub_s;
    logic       rsv_nz_s;

    assign cls_s = opc[OPW-1:OPW-2];
    assign sub_s = opc[1:0];

    if (OPW > 4) begin : g_rsv
        assign rsv_nz_s = |opc[OPW-3:2];
    end else begin : g_no_rsv
        assign rsv_nz_s = 1'b0;
    end

    // Any nonzero reserved bit forces a NOP, whatever the class says.
    always_comb begin
        dec = '0;
        if (rsv_nz_s) begin
            dec.pc_inc = 1'b1;
        end else begin
            case (cls_s)
                CLS_ALU_REG: begin
                    dec.reg_en = 1'b1;
                    dec.pc_inc = 1'b1;
                end
                CLS_ALU_IMM: begin
                    dec.reg_en  = 1'b1;
                    dec.imm_sel = 1'b1;
                    dec.pc_inc  = 1'b1;
                end
                CLS_BRANCH: begin
                    if (branch_taken(sub_s, zf, cf)) begin
                        dec.jmp_sel = 1'b1;
                    end else begin
                        dec.pc_inc = 1'b1;
                    end
                end
                CLS_SYS: begin
                    case (sub_s)
                        SUB_LOAD, SUB_STORE: dec.to_mem  = 1'b1;
                        SUB_HALT:            dec.to_halt = 1'b1;
                        default:             dec.pc_inc  = 1'b1;
                    endcase
                end
                default: dec.pc_inc = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction sequencer FETCH/DECODE/EXEC/MEM/HALT.
// Define CTRL_INSTR_CNT_EN to add the retired-instruction counter port instr_cnt.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CTRL_INSTR_CNT_EN
    output logic [CNT_W-1:0] instr_cnt,
`endif
    ctrl_fsm_if.slave        bus
);
    state_e         state_q, state_d;
    logic [OPW-1:0] opc_q, opc_d;
    logic [1:0]     alu_op_q, alu_op_d;
    exec_dec_t      dec_s;

    logic mem_req_s, mem_we_s, ir_load_s, pc_inc_s, jmp_sel_s, imm_sel_s, reg_en_s, halted_s;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opc (opc_q),
        .zf  (bus.zf),
        .cf  (bus.cf),
        .dec (dec_s)
    );

    // State, latched opcode and ALU sub-op registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            opc_q    <= '0;
            alu_op_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            alu_op_q <= alu_op_d;
        end
    end

    // Next state and strobes; FETCH outputs are qualified by rst_n so they stay low while reset is held.
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        alu_op_d  = alu_op_q;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
        ir_load_s = 1'b0;
        pc_inc_s  = 1'b0;
        jmp_sel_s = 1'b0;
        imm_sel_s = 1'b0;
        reg_en_s  = 1'b0;
        halted_s  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req_s = rst_n;
                if (bus.mem_ack) begin
                    ir_load_s = rst_n;
                    state_d   = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                opc_d    = bus.opcode;
                alu_op_d = bus.opcode[1:0];
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                reg_en_s  = dec_s.reg_en;
                imm_sel_s = dec_s.imm_sel;
                pc_inc_s  = dec_s.pc_inc;
                jmp_sel_s = dec_s.jmp_sel;
                if (dec_s.to_mem) begin
                    state_d = ST_MEM;
                end else if (dec_s.to_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req_s = 1'b1;
                mem_we_s  = (opc_q[1:0] == SUB_STORE);
                if (bus.mem_ack) begin
                    reg_en_s = (opc_q[1:0] == SUB_LOAD);
                    pc_inc_s = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_HALT: begin
                halted_s = 1'b1;
                state_d  = ST_HALT;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.mem_req = mem_req_s;
    assign bus.mem_we  = mem_we_s;
    assign bus.ir_load = ir_load_s;
    assign bus.pc_inc  = pc_inc_s;
    assign bus.jmp_sel = jmp_sel_s;
    assign bus.imm_sel = imm_sel_s;
    assign bus.reg_en  = reg_en_s;
    assign bus.halted  = halted_s;
    assign bus.alu_op  = alu_op_q;
    assign bus.state   = state_q;

`ifdef CTRL_INSTR_CNT_EN
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // One retirement per pc_inc or jmp_sel strobe; wraps naturally.
    always_comb begin
        if (pc_inc_s || jmp_sel_s) begin
            instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instr_cnt_d = instr_cnt_q;
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
`endif
endmodule
